// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to instruction
// memory, buffers the in-order responses with their PCs for decode, and
// flushes and retargets on a control-flow redirect. Responses owed to
// requests issued before a redirect are counted and discarded on arrival.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic [CW:0]   occupancy;
  logic [31:0]   redirect_tgt;
  logic          req_fire;
  logic          resp_live;
  logic          resp_stale;
  logic          pop;

  // Handshake qualifiers; a response in a redirect cycle is never written.
  always_comb begin
    redirect_tgt  = redirect_pc & ~32'd3;
    occupancy     = {1'b0, fifo_count} + {1'b0, inflight};
    mem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_L);
    mem_req_addr  = fetch_pc;
    req_fire      = mem_req_valid && mem_req_ready;
    resp_stale    = mem_resp_valid && (drop != '0);
    resp_live     = mem_resp_valid && (drop == '0) && !redirect_valid;
    out_valid     = !reset && (fifo_count != '0);
    out_inst      = out_valid ? inst_mem[rd_ptr] : 32'h0;
    out_pc        = out_valid ? pc_mem[rd_ptr]   : 32'h0;
    pop           = out_valid && out_ready;
  end

  // Control state: PCs, occupancy, in-flight and stale-response accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      fifo_count <= '0;
      inflight   <= '0;
      drop       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (redirect_valid) begin
      // Everything still owed by memory becomes stale, except the response
      // landing this cycle, which is already being thrown away.
      fetch_pc   <= redirect_tgt;
      resp_pc    <= redirect_tgt;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      inflight   <= inflight - CW'(mem_resp_valid);
      drop       <= inflight - CW'(mem_resp_valid);
    end else begin
      if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(mem_resp_valid);
      if (resp_stale)
        drop <= drop - CW'(1);
      if (resp_live) begin
        wr_ptr  <= wr_ptr + PW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({resp_live, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Buffer storage: capture each live response with the PC it belongs to.
  always_ff @(posedge clk) begin
    if (!reset && resp_live) begin
      inst_mem[wr_ptr] <= mem_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with programmable
// latency, scoreboard of live fetch addresses, table of redirect scenarios
// and hand-written reset/redirect corner sequences.
module tb_inst_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
  } pend_t;

  typedef struct {
    int          lat;
    int          warm;
    bit          ordy;
    logic [31:0] rpc;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } rvec_t;

  pend_t       pending[$];
  logic [31:0] sb[$];
  logic [31:0] pops[$];
  int          nchecks = 0;
  int          nerrors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          fifo_m = 0;
  int          fires = 0;
  int          npops = 0;
  logic [31:0] first_fire_addr;
  logic [31:0] exp_fetch = RPC;
  bit          prev_stall = 0;
  logic [31:0] prev_addr;
  bit          g_reset = 1, g_ready = 1, g_ordy = 1, g_redir = 0;
  logic [31:0] g_rpc = 32'h0;

  function automatic logic [31:0] image(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample/check 1ns later, update models.
  task automatic cycle();
    pend_t p;
    @(negedge clk);
    reset          = g_reset;
    mem_req_ready  = g_ready;
    out_ready      = g_ordy;
    redirect_valid = g_redir;
    redirect_pc    = g_rpc;
    if (!g_reset && pending.size() > 0 && pending[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = image(pending[0].addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (g_reset) begin
      check("rst_req_valid", mem_req_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_inst", out_inst, 0);
      check("rst_out_pc", out_pc, 0);
      pending.delete();
      sb.delete();
      pops.delete();
      fifo_m     = 0;
      exp_fetch  = RPC;
      prev_stall = 0;
    end else begin
      check("req_valid", mem_req_valid, (!g_redir && (fifo_m + pending.size()) < DEPTH));
      check("out_valid", out_valid, fifo_m != 0);
      if (mem_req_valid) check("req_addr", mem_req_addr, exp_fetch);
      if (prev_stall && !g_redir) begin
        check("stall_valid", mem_req_valid, 1);
        check("stall_addr", mem_req_addr, prev_addr);
      end
      prev_stall = mem_req_valid && !g_ready;
      prev_addr  = mem_req_addr;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchecks++;
          nerrors++;
          $display("FAIL pop_unexpected: got pc %h expected no output (cycle %0d)", out_pc, cyc);
        end else begin
          check("out_pc", out_pc, sb[0]);
          check("out_inst", out_inst, image(sb[0]));
          void'(sb.pop_front());
        end
        pops.push_back(out_pc);
        npops++;
        if (fifo_m > 0) fifo_m--;
      end
      if (mem_resp_valid) begin
        p = pending.pop_front();
        if (!g_redir && p.live) fifo_m++;
      end
      if (mem_req_valid && g_ready) begin
        if (fires == 0) first_fire_addr = exp_fetch;
        pending.push_back('{exp_fetch, cyc + lat, 1'b1});
        sb.push_back(exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        fires++;
      end
      if (g_redir) begin
        sb.delete();
        pops.delete();
        foreach (pending[i]) pending[i].live = 1'b0;
        fifo_m    = 0;
        exp_fetch = g_rpc & ~32'd3;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    g_reset = 1;
    g_redir = 0;
    run(2);
    g_reset = 0;
  endtask

  initial begin
    rvec_t tv[4];
    tv[0] = '{4, 3, 1'b1, 32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
    tv[1] = '{1, 6, 1'b1, 32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    tv[2] = '{2, 5, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    tv[3] = '{1, 2, 1'b0, 32'h0000_0042, 32'h0000_0040, 32'h0000_0044};

    reset = 1; mem_req_ready = 0; out_ready = 0; redirect_valid = 0;
    redirect_pc = 0; mem_resp_valid = 0; mem_resp_data = 0;

    // Steady-state streaming, one instruction per cycle.
    g_ready = 1; g_ordy = 1; lat = 1;
    do_reset();
    cycle();
    check("first_req_valid", mem_req_valid, 1);
    check("first_req_addr", mem_req_addr, RPC);
    run(3);
    npops = 0;
    run(16);
    check("steady_rate", npops, 16);

    // Decode stalled: exactly DEPTH fetches, then resume at 0x10.
    do_reset();
    g_ordy = 0; fires = 0;
    run(12);
    check("full_fires", fires, DEPTH);
    check("full_req_valid", mem_req_valid, 0);
    check("full_out_valid", out_valid, 1);
    g_ordy = 1; fires = 0;
    run(4);
    check("resume_addr", first_fire_addr, 32'h10);
    run(6);

    // Redirect scenarios.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      lat = tv[t].lat; g_ordy = tv[t].ordy;
      run(tv[t].warm);
      g_redir = 1; g_rpc = tv[t].rpc;
      cycle();
      g_redir = 0; g_ordy = 1;
      for (int k = 0; k < 60 && pops.size() < 2; k++) cycle();
      if (pops.size() < 2) begin
        nchecks++;
        nerrors++;
        $display("FAIL redir_timeout[%0d]: got %0d outputs expected 2", t, pops.size());
      end else begin
        check("redir_pc0", pops[0], tv[t].exp0);
        check("redir_pc1", pops[1], tv[t].exp1);
      end
      run(4);
    end

    // Redirect coinciding with a response and an output handshake.
    do_reset();
    lat = 1; g_ordy = 1;
    run(6);
    g_redir = 1; g_rpc = 32'h0000_0300;
    cycle();
    check("r37_handshake", out_valid && out_ready && mem_resp_valid, 1);
    g_redir = 0;
    cycle();
    check("r37_out_empty", out_valid, 0);
    check("r37_req_addr", mem_req_addr, 32'h300);
    run(10);

    // Reset with requests in flight and the buffer half full.
    do_reset();
    lat = 3; g_ordy = 0;
    run(5);
    check("r39_pre_out_valid", out_valid, 1);
    g_reset = 1;
    cycle();
    g_reset = 0; g_ordy = 1;
    cycle();
    check("r39_out_valid", out_valid, 0);
    check("r39_req_valid", mem_req_valid, 1);
    check("r39_req_addr", mem_req_addr, RPC);
    run(10);

    // Random traffic with backpressure and occasional redirects.
    for (int c = 0; c < 4; c++) begin
      lat = 1 + (c % 3);
      for (int k = 0; k < 100; k++) begin
        g_ready = ($urandom_range(0, 9) < 7);
        g_ordy  = ($urandom_range(0, 9) < 6);
        g_redir = ($urandom_range(0, 19) == 0);
        g_rpc   = $urandom;
        cycle();
      end
    end
    g_redir = 0; g_ready = 1; g_ordy = 1;
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
